// File: rtl/mbus_arbiter.sv
// mbus_arbiter: two-master round-robin arbiter for the MADDR/MDATA/MBE/MEN/MRW/MWAIT
// data bus. Master 0 is the core data port, master 1 is DMA/debug. Ownership is
// granted per transaction, parks on the last owner, and the owner's signals are
// muxed combinationally onto the slave side.
// Optional feature: define MBUS_TIMEOUT_EN to enable the stalled-bus watchdog
// (forced abort after TIMEOUT_CYCLES stalled cycles, sticky bus_err/err_addr).
module mbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m0_be,
  input  logic [3:0]  m1_be,
  input  logic        m0_en,
  input  logic        m1_en,
  input  logic        m0_rw,
  input  logic        m1_rw,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_wait,
  output logic        m1_wait,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_be,
  output logic        s_en,
  output logic        s_rw,
  input  logic [31:0] s_rdata,
  input  logic        s_wait,
  output logic [1:0]  gnt,
  output logic        bus_err,
  output logic [31:0] err_addr,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
`ifdef MBUS_TIMEOUT_EN
    , ABORT = 2'd3
`endif
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   own0, own1;
  logic   timeout;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);
  assign gnt  = {own1, own0};

  // Slave-side mux: the owner's request passes straight through, otherwise the bus is quiet
  always_comb begin
    s_addr  = 32'h0;
    s_wdata = 32'h0;
    s_be    = 4'h0;
    s_en    = 1'b0;
    s_rw    = 1'b0;
    if (own0) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_be    = m0_be;
      s_en    = m0_en;
      s_rw    = m0_rw;
    end else if (own1) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_be    = m1_be;
      s_en    = m1_en;
      s_rw    = m1_rw;
    end
  end

  // Master-side responses: only the owner can finish; a watchdog abort finishes it with a poison word
  always_comb begin
    m0_wait  = m0_en & ~(own0 & s_en & (~s_wait | timeout));
    m1_wait  = m1_en & ~(own1 & s_en & (~s_wait | timeout));
    m0_rdata = 32'h0;
    m1_rdata = 32'h0;
    if (own0) m0_rdata = timeout ? 32'hDEAD_BEEF : s_rdata;
    if (own1) m1_rdata = timeout ? 32'hDEAD_BEEF : s_rdata;
  end

  // Ownership FSM: round-robin on ties, park after completion, release when the owner stops requesting
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_en && m1_en) state_d = last_q ? OWN0 : OWN1;
        else if (m0_en)     state_d = OWN0;
        else if (m1_en)     state_d = OWN1;
      end
      OWN0: begin
`ifdef MBUS_TIMEOUT_EN
        if (timeout) state_d = ABORT;
        else
`endif
        if (m0_en && !s_wait) begin
          last_d  = 1'b0;
          state_d = m1_en ? OWN1 : OWN0;
        end else if (!m0_en) begin
          state_d = m1_en ? OWN1 : IDLE;
        end
      end
      OWN1: begin
`ifdef MBUS_TIMEOUT_EN
        if (timeout) state_d = ABORT;
        else
`endif
        if (m1_en && !s_wait) begin
          last_d  = 1'b1;
          state_d = m0_en ? OWN0 : OWN1;
        end else if (!m1_en) begin
          state_d = m0_en ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer; master 0 wins the first tie after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

`ifdef MBUS_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT_CYCLES);

  logic [7:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;

  assign timeout  = s_en & (cnt_q == TIMEOUT_CNT);
  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;

  // Watchdog: count consecutive stalled cycles, record the first offending address, set beats clear
  always_comb begin
    cnt_d      = (s_en && s_wait && !timeout) ? cnt_q + 8'd1 : 8'd0;
    bus_err_d  = timeout | (bus_err_q & ~err_clr);
    err_addr_d = (timeout && !bus_err_q) ? s_addr : err_addr_q;
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 8'd0;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end
`else
  assign timeout  = 1'b0;
  assign bus_err  = 1'b0;
  assign err_addr = 32'h0;
`endif

endmodule

// File: tb/tb_mbus_arbiter.sv
// tb_mbus_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the two-master arbiter.
module tb_mbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_en, m1_en, m0_rw, m1_rw;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_wait, m1_wait;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_en, s_rw;
  logic [31:0] s_rdata;
  logic        s_wait;
  logic [1:0]  gnt;
  logic        bus_err;
  logic [31:0] err_addr;
  logic        err_clr;

  int checks = 0;
  int passes = 0;

  mbus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_be(m0_be), .m1_be(m1_be),
    .m0_en(m0_en), .m1_en(m1_en),
    .m0_rw(m0_rw), .m1_rw(m1_rw),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_wait(m0_wait), .m1_wait(m1_wait),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be), .s_en(s_en), .s_rw(s_rw),
    .s_rdata(s_rdata), .s_wait(s_wait),
    .gnt(gnt), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
    m0_be = 4'h0; m1_be = 4'h0; m0_en = 1'b0; m1_en = 1'b0;
    m0_rw = 1'b0; m1_rw = 1'b0; s_rdata = 32'h0; s_wait = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    m0_en = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) $display("[TB] FAIL reset_gnt got %b want %b", gnt, 2'b00); else passes++;
    checks++; if (s_en !== 1'b0) $display("[TB] FAIL reset_s_en got %b want 0", s_en); else passes++;
    checks++; if (m0_wait !== 1'b1) $display("[TB] FAIL reset_m0_wait got %b want 1", m0_wait); else passes++;
    checks++; if (bus_err !== 1'b0) $display("[TB] FAIL reset_bus_err got %b want 0", bus_err); else passes++;
    checks++; if (err_addr !== 32'h0) $display("[TB] FAIL reset_err_addr got %h want 0", err_addr); else passes++;
    tick();
    rst = 1'b0;
    m0_en = 1'b0;
  endtask

  task automatic test_single_read();
    m0_en = 1'b1; m0_rw = 1'b0; m0_addr = 32'h0000_1000; m0_be = 4'hF;
    s_wait = 1'b0; s_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (s_en !== 1'b0) $display("[TB] FAIL read_arb_s_en got %b want 0", s_en); else passes++;
    checks++; if (m0_wait !== 1'b1) $display("[TB] FAIL read_arb_wait got %b want 1", m0_wait); else passes++;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) $display("[TB] FAIL read_gnt got %b want 01", gnt); else passes++;
    checks++; if (s_en !== 1'b1) $display("[TB] FAIL read_s_en got %b want 1", s_en); else passes++;
    checks++; if (s_addr !== 32'h0000_1000) $display("[TB] FAIL read_s_addr got %h want 00001000", s_addr); else passes++;
    checks++; if (m0_rdata !== 32'h1234_5678) $display("[TB] FAIL read_rdata got %h want 12345678", m0_rdata); else passes++;
    checks++; if (m0_wait !== 1'b0) $display("[TB] FAIL read_wait got %b want 0", m0_wait); else passes++;
    tick();
    m0_en = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) $display("[TB] FAIL read_parked got %b want 01", gnt); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    for (int i = 0; i < 4; i++) begin
      wd = $urandom;
      m0_en = 1'b1; m0_rw = 1'b1; m0_be = 4'b0011;
      m0_addr = 32'h0000_2000 + 32'(4 * i); m0_wdata = wd;
      @(negedge clk);
      checks++; if (m0_wait !== 1'b0) $display("[TB] FAIL b2b_wait[%0d] got %b want 0", i, m0_wait); else passes++;
      checks++; if ({s_en, s_rw, s_be} !== 6'b11_0011) $display("[TB] FAIL b2b_ctl[%0d] got %b want 110011", i, {s_en, s_rw, s_be}); else passes++;
      checks++; if (s_addr !== 32'h0000_2000 + 32'(4 * i)) $display("[TB] FAIL b2b_addr[%0d] got %h want %h", i, s_addr, 32'h0000_2000 + 32'(4 * i)); else passes++;
      checks++; if (s_wdata !== wd) $display("[TB] FAIL b2b_wdata[%0d] got %h want %h", i, s_wdata, wd); else passes++;
      checks++; if (gnt !== 2'b01) $display("[TB] FAIL b2b_gnt[%0d] got %b want 01", i, gnt); else passes++;
      tick();
    end
    m0_en = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b00) $display("[TB] FAIL b2b_release got %b want 00", gnt); else passes++;
  endtask

  task automatic test_alternate();
    logic [1:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_en = 1'b1; m1_en = 1'b1; m0_addr = 32'hA0; m1_addr = 32'hB0; s_wait = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      checks++; if (gnt !== want) $display("[TB] FAIL alt_gnt[%0d] got %b want %b", i, gnt, want); else passes++;
      checks++; if ({m1_wait, m0_wait} !== ~want) $display("[TB] FAIL alt_wait[%0d] got %b want %b", i, {m1_wait, m0_wait}, ~want); else passes++;
      tick();
    end
    m0_en = 1'b0; m1_en = 1'b0;
    tick();
  endtask

  task automatic test_stall_handover();
    m1_en = 1'b1; m1_addr = 32'h0000_0400; m1_rw = 1'b0;
    tick();
    m0_en = 1'b1; s_wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({gnt, m1_wait, m0_wait} !== 4'b1011) $display("[TB] FAIL stall[%0d] gnt/waits got %b want 1011", i, {gnt, m1_wait, m0_wait}); else passes++;
      tick();
    end
    s_wait = 1'b0;
    @(negedge clk);
    checks++; if ({m1_wait, m0_wait} !== 2'b01) $display("[TB] FAIL stall_done waits got %b want 01", {m1_wait, m0_wait}); else passes++;
    tick();
    m1_en = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 2'b01) $display("[TB] FAIL stall_handover gnt got %b want 01", gnt); else passes++;
    checks++; if (m0_wait !== 1'b0) $display("[TB] FAIL stall_handover m0_wait got %b want 0", m0_wait); else passes++;
    tick();
    m0_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    m1_en = 1'b1; m1_addr = 32'h0000_0800; s_wait = 1'b1;
    tick();
    @(negedge clk);
    checks++; if ({gnt, s_en, m1_wait} !== 4'b1011) $display("[TB] FAIL rstmid_pre got %b want 1011", {gnt, s_en, m1_wait}); else passes++;
    rst = 1'b1; m0_en = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, s_en} !== 3'b000) $display("[TB] FAIL rstmid_post got %b want 000", {gnt, s_en}); else passes++;
    s_wait = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (gnt !== 2'b01) $display("[TB] FAIL rstmid_tie got %b want 01", gnt); else passes++;
    checks++; if ({m1_wait, m0_wait} !== 2'b10) $display("[TB] FAIL rstmid_waits got %b want 10", {m1_wait, m0_wait}); else passes++;
    m0_en = 1'b0; m1_en = 1'b0;
    tick();
    tick();
  endtask

`ifdef MBUS_TIMEOUT_EN
  task automatic test_timeout();
    m0_en = 1'b1; m0_rw = 1'b0; m0_addr = 32'h8000_0004; s_wait = 1'b1; s_rdata = 32'h5555_AAAA;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (m0_wait !== 1'b1) $display("[TB] FAIL to_stall[%0d] got %b want 1", i, m0_wait); else passes++;
      tick();
    end
    @(negedge clk);
    checks++; if (m0_wait !== 1'b0) $display("[TB] FAIL to_wait got %b want 0", m0_wait); else passes++;
    checks++; if (m0_rdata !== 32'hDEAD_BEEF) $display("[TB] FAIL to_rdata got %h want deadbeef", m0_rdata); else passes++;
    tick();
    m0_en = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, s_en} !== 3'b000) $display("[TB] FAIL to_abort got %b want 000", {gnt, s_en}); else passes++;
    checks++; if (bus_err !== 1'b1) $display("[TB] FAIL to_bus_err got %b want 1", bus_err); else passes++;
    checks++; if (err_addr !== 32'h8000_0004) $display("[TB] FAIL to_err_addr got %h want 80000004", err_addr); else passes++;
    tick();
    err_clr = 1'b1; s_wait = 1'b0;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    checks++; if (bus_err !== 1'b0) $display("[TB] FAIL to_clear got %b want 0", bus_err); else passes++;
  endtask
`endif

  task automatic test_random();
    int          owner;
    bit          lastM;
    bit          busy [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  bm [2];
    bit          wr [2];
    int          stallRun;
    bit          doRst, sen, done;
    logic [1:0]  expGnt;
    logic [31:0] expAddr, expWdata, expRd0, expRd1;
    logic [3:0]  expBe;
    logic        expRw, expW0, expW1;
    int          cur, oth;

    rst = 1'b1; idle_inputs();
    tick();
    rst = 1'b0;
    owner = -1; lastM = 1'b1; stallRun = 0;
    for (int x = 0; x < 2; x++) begin
      busy[x] = 1'b0; ad[x] = 32'h0; wd[x] = 32'h0; bm[x] = 4'h0; wr[x] = 1'b0;
    end

    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int x = 0; x < 2; x++) begin
        if (busy[x]) begin
          if ($urandom_range(31) == 0) busy[x] = 1'b0;
        end else if ($urandom_range(1) == 1) begin
          busy[x] = 1'b1; ad[x] = $urandom; wd[x] = $urandom;
          bm[x] = 4'($urandom); wr[x] = 1'($urandom);
        end
      end
      s_wait = (stallRun < 4) && ($urandom_range(2) == 0);
      stallRun = s_wait ? stallRun + 1 : 0;
      s_rdata = $urandom;
      doRst = ($urandom_range(99) == 0);
      rst = doRst;
      m0_en = busy[0]; m0_addr = ad[0]; m0_wdata = wd[0]; m0_be = bm[0]; m0_rw = wr[0];
      m1_en = busy[1]; m1_addr = ad[1]; m1_wdata = wd[1]; m1_be = bm[1]; m1_rw = wr[1];

      @(negedge clk);
      sen      = (owner >= 0) ? busy[owner] : 1'b0;
      done     = sen && !s_wait;
      expGnt   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
      expAddr  = (owner >= 0) ? ad[owner] : 32'h0;
      expWdata = (owner >= 0) ? wd[owner] : 32'h0;
      expBe    = (owner >= 0) ? bm[owner] : 4'h0;
      expRw    = (owner >= 0) ? wr[owner] : 1'b0;
      expW0    = busy[0] && !(owner == 0 && done);
      expW1    = busy[1] && !(owner == 1 && done);
      expRd0   = (owner == 0) ? s_rdata : 32'h0;
      expRd1   = (owner == 1) ? s_rdata : 32'h0;
      checks++; if (gnt !== expGnt) $display("[TB] FAIL rnd_gnt c%0d got %b want %b", cyc, gnt, expGnt); else passes++;
      checks++; if (s_en !== sen) $display("[TB] FAIL rnd_s_en c%0d got %b want %b", cyc, s_en, sen); else passes++;
      checks++; if ({s_addr, s_wdata, s_be, s_rw} !== {expAddr, expWdata, expBe, expRw}) $display("[TB] FAIL rnd_slave c%0d got %h/%h/%h/%b want %h/%h/%h/%b", cyc, s_addr, s_wdata, s_be, s_rw, expAddr, expWdata, expBe, expRw); else passes++;
      checks++; if ({m0_wait, m1_wait} !== {expW0, expW1}) $display("[TB] FAIL rnd_wait c%0d got %b want %b", cyc, {m0_wait, m1_wait}, {expW0, expW1}); else passes++;
      checks++; if ({m0_rdata, m1_rdata} !== {expRd0, expRd1}) $display("[TB] FAIL rnd_rdata c%0d got %h/%h want %h/%h", cyc, m0_rdata, m1_rdata, expRd0, expRd1); else passes++;
      checks++; if (bus_err !== 1'b0) $display("[TB] FAIL rnd_bus_err c%0d got %b want 0", cyc, bus_err); else passes++;

      if (doRst) begin
        owner = -1; lastM = 1'b1; busy[0] = 1'b0; busy[1] = 1'b0;
      end else if (owner < 0) begin
        if (busy[0] && busy[1]) owner = lastM ? 0 : 1;
        else if (busy[0])       owner = 0;
        else if (busy[1])       owner = 1;
      end else begin
        cur = owner; oth = 1 - owner;
        if (done) begin
          lastM = cur[0];
          busy[cur] = 1'b0;
          owner = busy[oth] ? oth : cur;
        end else if (!busy[cur]) begin
          owner = busy[oth] ? oth : -1;
        end
      end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_alternate();
    test_stall_handover();
    test_reset_mid();
`ifdef MBUS_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
